// File: rtl/mult_job_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : mult_job_sequencer_if
//  Description : Handshake bundle for mult_job_sequencer.
//                Upstream   : in_valid/in_ready with signed operands in_a/in_b.
//                Multiplier : mul_a/mul_b operands, mul_start pulse,
//                             mul_done strobe and 2N-bit mul_result.
//                Downstream : out_valid/out_ready with out_result and out_err.
//                slave  = sequencer side, master = environment side.
//  Revision    : 1.0 - initial release
// ============================================================================
interface mult_job_sequencer_if #(
    parameter int N = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [N-1:0]     in_a;
    logic [N-1:0]     in_b;
    logic [N-1:0]     mul_a;
    logic [N-1:0]     mul_b;
    logic             mul_start;
    logic             mul_done;
    logic [2*N-1:0]   mul_result;
    logic             out_valid;
    logic             out_ready;
    logic [2*N-1:0]   out_result;
    logic             out_err;

    modport slave (
        input  in_valid, in_a, in_b, mul_done, mul_result, out_ready,
        output in_ready, mul_a, mul_b, mul_start, out_valid, out_result, out_err
    );

    modport master (
        output in_valid, in_a, in_b, mul_done, mul_result, out_ready,
        input  in_ready, mul_a, mul_b, mul_start, out_valid, out_result, out_err
    );
endinterface
`default_nettype wire

// File: rtl/mult_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : mult_job_sequencer
//  Description : Operand/result sequencer around a signed multiplier.
//                Operand pairs are queued in a DEPTH-entry FIFO, issued to the
//                multiplier one at a time with a single-cycle start pulse, and
//                the product (or a zero/error result on timeout) is held on
//                the output handshake until accepted.
//  Ports       : clk       - clock, rising edge
//                reset     - asynchronous active-low reset
//                bus       - mult_job_sequencer_if.slave (in_*, mul_*, out_*)
//                busy      - FSM not IDLE or FIFO non-empty
//                jobs_done - count of completed output handshakes (wraps)
//  Revision    : 1.0 - initial release
// ============================================================================
module mult_job_sequencer #(
    parameter int N       = 8,
    parameter int DEPTH   = 2,
    parameter int TIMEOUT = 31
) (
    input  wire logic               clk,
    input  wire logic               reset,
    mult_job_sequencer_if.slave     bus,
    output logic                    busy,
    output logic [15:0]             jobs_done
);

    localparam int c_AW    = $clog2(DEPTH);
    localparam int c_CNT_W = c_AW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_HOLD  = 2'd3
    } state_t;

    state_t             r_state;
    logic [N-1:0]       r_mem_a [DEPTH];
    logic [N-1:0]       r_mem_b [DEPTH];
    logic [c_AW-1:0]    r_wr_ptr;
    logic [c_AW-1:0]    r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;
    logic [7:0]         r_timer;
    logic [N-1:0]       r_mul_a;
    logic [N-1:0]       r_mul_b;
    logic               r_mul_start;
    logic               r_out_valid;
    logic [2*N-1:0]     r_out_result;
    logic               r_out_err;
    logic [15:0]        r_jobs_done;

    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;

    assign w_full  = (r_count == c_CNT_W'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.in_valid && !w_full;
    // The FSM is the only consumer, and it only pops while IDLE.
    assign w_pop   = (r_state == S_IDLE) && !w_empty;

    // Storage carries no reset: its contents are unobservable while the
    // pointers and count say the FIFO is empty.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_a[r_wr_ptr] <= bus.in_a;
            r_mem_b[r_wr_ptr] <= bus.in_b;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_wr_ptr     <= '0;
            r_rd_ptr     <= '0;
            r_count      <= '0;
            r_timer      <= '0;
            r_mul_a      <= '0;
            r_mul_b      <= '0;
            r_mul_start  <= 1'b0;
            r_out_valid  <= 1'b0;
            r_out_result <= '0;
            r_out_err    <= 1'b0;
            r_jobs_done  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (w_push) r_wr_ptr <= r_wr_ptr + c_AW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + c_AW'(1);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + c_CNT_W'(1);
                2'b01:   r_count <= r_count - c_CNT_W'(1);
                default: r_count <= r_count;
            endcase

            // Start is high only in the single ISSUE cycle.
            r_mul_start <= 1'b0;

            case (r_state)
                S_IDLE: begin
                    if (!w_empty) begin
                        r_mul_a     <= r_mem_a[r_rd_ptr];
                        r_mul_b     <= r_mem_b[r_rd_ptr];
                        r_mul_start <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_timer <= '0;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    // A completion on the final timeout cycle still wins.
                    if (bus.mul_done) begin
                        r_out_result <= bus.mul_result;
                        r_out_err    <= 1'b0;
                        r_out_valid  <= 1'b1;
                        r_state      <= S_HOLD;
                    end else if (r_timer == 8'(TIMEOUT)) begin
                        r_out_result <= '0;
                        r_out_err    <= 1'b1;
                        r_out_valid  <= 1'b1;
                        r_state      <= S_HOLD;
                    end else begin
                        r_timer <= r_timer + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_jobs_done <= r_jobs_done + 16'd1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = !w_full;
    assign bus.mul_a      = r_mul_a;
    assign bus.mul_b      = r_mul_b;
    assign bus.mul_start  = r_mul_start;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_result = r_out_result;
    assign bus.out_err    = r_out_err;
    assign busy           = (r_state != S_IDLE) || !w_empty;
    assign jobs_done      = r_jobs_done;

endmodule
`default_nettype wire

// File: tb/tb_mult_job_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mult_job_sequencer
//  Description : Self-checking bench for mult_job_sequencer (N=8, DEPTH=2,
//                TIMEOUT=31). A table of single jobs with hand-computed
//                products is applied in a loop, followed by hand-written
//                sequences for backpressure, output stall, spurious done and
//                asynchronous reset mid-job.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mult_job_sequencer;

    localparam int N       = 8;
    localparam int DEPTH   = 2;
    localparam int TIMEOUT = 31;

    logic        clk;
    logic        reset;
    logic        busy;
    logic [15:0] jobs_done;

    mult_job_sequencer_if #(.N(N)) mif ();

    mult_job_sequencer #(.N(N), .DEPTH(DEPTH), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (mif.slave),
        .busy      (busy),
        .jobs_done (jobs_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- multiplier model ----------------
    // model_lat = cycles from the start cycle to the done cycle; 0 = never.
    int               model_lat = 3;
    int               m_cnt;
    logic             model_done;
    logic [15:0]      model_res;
    logic             manual_done;
    logic signed [15:0] pa, pb;

    always @(negedge clk or negedge reset) begin
        if (!reset) begin
            m_cnt      = 0;
            model_done = 1'b0;
        end else begin
            model_done = 1'b0;
            if (mif.mul_start) begin
                m_cnt     = model_lat;
                pa        = $signed(mif.mul_a);
                pb        = $signed(mif.mul_b);
                model_res = pa * pb;
            end else if (m_cnt > 0) begin
                m_cnt--;
                if (m_cnt == 0) model_done = 1'b1;
            end
        end
    end

    assign mif.mul_done   = model_done | manual_done;
    assign mif.mul_result = model_res;

    // ---------------- vector table ----------------
    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        int          lat;
        logic [15:0] res;
        logic        err;
        int          exp_lat;   // negedges from the start cycle to out_valid
    } vec_t;

    vec_t vecs [7];

    task automatic handshake(input string name);
        logic [15:0] jd;
        jd = jobs_done;
        mif.out_ready = 1'b1;
        @(negedge clk);
        mif.out_ready = 1'b0;
        check({name, "_valid_drop"}, 32'(mif.out_valid), 32'd0);
        check({name, "_jobs_done"}, 32'(jobs_done), 32'(16'(jd + 16'd1)));
    endtask

    task automatic push(input logic [7:0] a, input logic [7:0] b);
        int n;
        @(negedge clk);
        mif.in_valid = 1'b1;
        mif.in_a     = a;
        mif.in_b     = b;
        n = 0;
        while (!mif.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check("push_timeout", 32'd1, 32'd0);
        @(negedge clk);
        mif.in_valid = 1'b0;
    endtask

    task automatic wait_valid(input string name);
        int n;
        n = 0;
        while (!mif.out_valid && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) check({name, "_valid_timeout"}, 32'd1, 32'd0);
    endtask

    task automatic run_job(input vec_t v);
        int   n;
        logic stable;
        model_lat = v.lat;
        @(negedge clk);
        mif.in_valid = 1'b1;
        mif.in_a     = v.a;
        mif.in_b     = v.b;
        check("in_ready", 32'(mif.in_ready), 32'd1);
        @(negedge clk);                       // push edge E0 has passed
        mif.in_valid = 1'b0;
        check("start_early", 32'(mif.mul_start), 32'd0);
        @(negedge clk);                       // pop edge E1 has passed
        check("start", 32'(mif.mul_start), 32'd1);
        check("mul_a", 32'(mif.mul_a), 32'(v.a));
        check("mul_b", 32'(mif.mul_b), 32'(v.b));
        @(negedge clk);
        check("start_pulse", 32'(mif.mul_start), 32'd0);
        n      = 1;
        stable = 1'b1;
        while (!mif.out_valid && n < 100) begin
            if (mif.mul_a !== v.a || mif.mul_b !== v.b || mif.mul_start !== 1'b0)
                stable = 1'b0;
            @(negedge clk);
            n++;
        end
        check("operands_stable", 32'(stable), 32'd1);
        check("out_latency", 32'(n), 32'(v.exp_lat));
        check("out_valid", 32'(mif.out_valid), 32'd1);
        check("out_result", 32'(mif.out_result), 32'(v.res));
        check("out_err", 32'(mif.out_err), 32'(v.err));
        handshake("job");
    endtask

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        logic [15:0] exp3 [3];
        logic        ok_a, ok_b, ok_c;
        int          n;
        logic [15:0] jd;

        vecs[0] = '{a: 8'h05, b: 8'hFD, lat: 3,  res: 16'hFFF1, err: 1'b0, exp_lat: 4};
        vecs[1] = '{a: 8'h7F, b: 8'h7F, lat: 1,  res: 16'h3F01, err: 1'b0, exp_lat: 2};
        vecs[2] = '{a: 8'hFF, b: 8'h01, lat: 5,  res: 16'hFFFF, err: 1'b0, exp_lat: 6};
        vecs[3] = '{a: 8'h00, b: 8'h9C, lat: 4,  res: 16'h0000, err: 1'b0, exp_lat: 5};
        vecs[4] = '{a: 8'h80, b: 8'h7F, lat: 0,  res: 16'h0000, err: 1'b1, exp_lat: 33};
        vecs[5] = '{a: 8'hC0, b: 8'h40, lat: 32, res: 16'hF000, err: 1'b0, exp_lat: 33};
        vecs[6] = '{a: 8'h80, b: 8'h80, lat: 2,  res: 16'h4000, err: 1'b0, exp_lat: 3};

        reset         = 1'b0;
        manual_done   = 1'b0;
        mif.in_valid  = 1'b0;
        mif.in_a      = '0;
        mif.in_b      = '0;
        mif.out_ready = 1'b0;

        // ---- reset state ----
        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(mif.out_valid), 32'd0);
        check("rst_mul_start", 32'(mif.mul_start), 32'd0);
        check("rst_mul_a", 32'(mif.mul_a), 32'd0);
        check("rst_out_result", 32'(mif.out_result), 32'd0);
        check("rst_out_err", 32'(mif.out_err), 32'd0);
        check("rst_jobs_done", 32'(jobs_done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 32'(mif.in_ready), 32'd1);

        // ---- table-driven single jobs (timeout followed by a normal job) ----
        for (int i = 0; i < 7; i++) run_job(vecs[i]);

        // ---- backpressure / full FIFO, multiplier slow ----
        model_lat = 20;
        exp3[0] = 16'h0006;   //   2 *  3
        exp3[1] = 16'h0001;   //  -1 * -1
        exp3[2] = 16'hFFEC;   //  10 * -2
        @(negedge clk);
        mif.in_valid = 1'b1; mif.in_a = 8'h02; mif.in_b = 8'h03;
        check("bp_ready0", 32'(mif.in_ready), 32'd1);
        @(negedge clk);
        mif.in_a = 8'hFF; mif.in_b = 8'hFF;
        check("bp_ready1", 32'(mif.in_ready), 32'd1);
        @(negedge clk);
        mif.in_a = 8'h0A; mif.in_b = 8'hFE;
        check("bp_ready2", 32'(mif.in_ready), 32'd1);
        @(negedge clk);
        check("bp_full", 32'(mif.in_ready), 32'd0);
        check("bp_busy", 32'(busy), 32'd1);
        // A fourth pair offered while full must be ignored.
        mif.in_a = 8'h55; mif.in_b = 8'h55;
        ok_a = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (mif.in_ready !== 1'b0) ok_a = 1'b0;
        end
        mif.in_valid = 1'b0;
        check("bp_full_held", 32'(ok_a), 32'd1);
        for (int i = 0; i < 3; i++) begin
            wait_valid("bp");
            check("bp_result", 32'(mif.out_result), 32'(exp3[i]));
            check("bp_err", 32'(mif.out_err), 32'd0);
            handshake("bp");
        end
        repeat (3) @(negedge clk);
        check("bp_drained", 32'(busy), 32'd0);

        // ---- output stall with a queued job ----
        model_lat = 2;
        push(8'h80, 8'h80);
        push(8'h03, 8'h04);
        wait_valid("stall");
        ok_a = 1'b1; ok_b = 1'b1; ok_c = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (mif.out_result !== 16'h4000) ok_a = 1'b0;
            if (mif.mul_start !== 1'b0)      ok_b = 1'b0;
            if (mif.out_valid !== 1'b1)      ok_c = 1'b0;
        end
        check("stall_result_held", 32'(ok_a), 32'd1);
        check("stall_no_start", 32'(ok_b), 32'd1);
        check("stall_valid_held", 32'(ok_c), 32'd1);
        handshake("stall");
        n = 0;
        while (!mif.mul_start && n < 10) begin
            @(negedge clk);
            n++;
        end
        check("stall_next_start", 32'(mif.mul_start), 32'd1);
        wait_valid("stall2");
        check("stall2_result", 32'(mif.out_result), 32'h000C);
        handshake("stall2");

        // ---- spurious done while IDLE ----
        repeat (2) @(negedge clk);
        jd = jobs_done;
        manual_done = 1'b1;
        ok_a = 1'b1;
        repeat (3) begin
            @(negedge clk);
            if (mif.out_valid !== 1'b0 || busy !== 1'b0 || mif.mul_start !== 1'b0) ok_a = 1'b0;
        end
        manual_done = 1'b0;
        check("idle_done_ignored", 32'(ok_a), 32'd1);
        check("idle_done_jobs", 32'(jobs_done), 32'(jd));
        run_job(vecs[0]);

        // ---- asynchronous reset mid-WAIT with one entry queued ----
        model_lat = 0;
        push(8'h11, 8'h22);
        push(8'h33, 8'h44);
        repeat (3) @(negedge clk);
        check("mid_busy", 32'(busy), 32'd1);
        #2 reset = 1'b0;
        #1;
        check("arst_mul_a", 32'(mif.mul_a), 32'd0);
        check("arst_mul_b", 32'(mif.mul_b), 32'd0);
        check("arst_out_result", 32'(mif.out_result), 32'd0);
        check("arst_out_valid", 32'(mif.out_valid), 32'd0);
        check("arst_jobs_done", 32'(jobs_done), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("post_busy", 32'(busy), 32'd0);
        check("post_jobs_done", 32'(jobs_done), 32'd0);
        check("post_in_ready", 32'(mif.in_ready), 32'd1);
        ok_a = 1'b1;
        repeat (40) begin
            @(negedge clk);
            if (mif.mul_start !== 1'b0 || mif.out_valid !== 1'b0) ok_a = 1'b0;
        end
        check("post_quiet", 32'(ok_a), 32'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mult_job_sequencer.md
Name: mult_job_sequencer

Overview:
Operand/result sequencer wrapped around the signed multiplier datapath.
- Upstream: accepts signed operand pairs over a valid/ready handshake into a small FIFO.
- Toward the multiplier: drives stable operands, pulses the multiplier's start input, and waits for a completion strobe.
- Downstream: captures the 2N-bit product and presents it over a valid/ready handshake.
- Adds a timeout so a hung multiplier cannot stall the pipeline.

Parameters:
N, 8, operand width in bits; the product is 2N bits.
DEPTH, 2, operand FIFO depth in entries; must be a power of 2, minimum 2.
TIMEOUT, 31, maximum cycles spent in WAIT before the job is aborted; range 1..255.

Ports:
clk  in  1  clock, rising edge.
reset  in  1  asynchronous, active-low reset; low clears all state.
in_valid  in  1  upstream operand pair valid.
in_ready  out  1  FIFO can accept an entry.
in_a  in  N  signed operand a.
in_b  in  N  signed operand b.
mul_a  out  N  operand a to the multiplier (registered).
mul_b  out  N  operand b to the multiplier (registered).
mul_start  out  1  one-cycle start pulse to the multiplier.
mul_done  in  1  multiplier completion strobe.
mul_result  in  2N  multiplier product; sampled only when mul_done is high in WAIT.
out_valid  out  1  result available.
out_ready  in  1  downstream accepts the result.
out_result  out  2N  captured product; 0 on timeout.
out_err  out  1  qualifies out_result; 1 means the job timed out.
busy  out  1  high when the FSM is not IDLE or the FIFO is non-empty.
jobs_done  out  16  count of completed output handshakes; wraps at 16'hFFFF to 0.

Behaviour:
Reset (reset low, asynchronous):
- FIFO empty, FSM in IDLE, timer = 0.
- mul_a = 0, mul_b = 0, mul_start = 0.
- out_valid = 0, out_result = 0, out_err = 0, jobs_done = 0.
- in_ready = 1 once reset is released.
- Reset asserted mid-job drops the in-flight job and all queued entries; no output is produced for them.

FIFO:
- in_ready = !full.
- A push happens on a rising edge with in_valid && in_ready.
- A pop is performed only by the FSM, in IDLE.
- A push and a pop on the same edge are both honoured and the count is unchanged.
- When full, in_ready = 0 and in_valid is ignored.
- Read/write pointers wrap modulo DEPTH.
- Data is not transformed; the sequencer is sign-agnostic.

FSM states: IDLE, ISSUE, WAIT, HOLD.
- IDLE: if the FIFO is non-empty, pop the head into mul_a/mul_b and go to ISSUE. Otherwise stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mul_start = 1.
  - Timer cleared.
  - Next state is WAIT.
- WAIT:
  - mul_start = 0; mul_a/mul_b held stable.
  - If mul_done = 1: out_result <= mul_result, out_err <= 0, out_valid <= 1, go to HOLD.
  - Else if timer == TIMEOUT: out_result <= 0, out_err <= 1, out_valid <= 1, go to HOLD.
  - Else timer increments.
  - mul_done takes priority over timeout when both occur in the same cycle.
- HOLD:
  - out_valid = 1; out_result and out_err are stable until accepted.
  - On out_valid && out_ready: out_valid <= 0, jobs_done increments, go to IDLE.
- mul_done is ignored in IDLE, ISSUE and HOLD.

Latency:
- FIFO empty and FSM in IDLE, push on edge E0: the FIFO is non-empty after E0, and the pop happens on edge E1.
- mul_start is high in the cycle following E1.
- A result captured on edge Ek gives out_valid high from Ek.
- The minimum gap between consecutive mul_start pulses is 4 cycles.

Test Plan:
- Single job: push a=8'd5, b=8'hFD; bench model asserts mul_done with result 16'hFFF1 three cycles after mul_start. Required: mul_start is a single-cycle pulse with mul_a=05 and mul_b=FD stable through WAIT; then out_valid=1, out_result=FFF1, out_err=0, jobs_done=1 after handshake.
- Backpressure/full: push 3 pairs back-to-back with DEPTH=2 and the multiplier stalled. Required: in_ready drops low once the FIFO is full; the third pair is accepted only after the first pop; all three results return in order.
- Output stall: hold out_ready=0 for 10 cycles after result 16'h4000 (a=8'h80, b=8'h80). Required: out_result held at 4000; no new mul_start until the handshake completes.
- Timeout: never assert mul_done, TIMEOUT=31. Required: out_valid rises with out_err=1 and out_result=0; the next queued job then issues normally.
- Done/timeout collision and spurious done: assert mul_done on the exact timeout cycle, and also in IDLE. Required: the collision gives out_err=0 with the captured result; mul_done in IDLE has no effect.
- Reset mid-WAIT with 1 entry queued: pull reset low asynchronously. Required: all outputs return to 0 immediately; after release the FIFO is empty, busy=0, jobs_done=0.
